// File: rtl/module_pc_unit_pkg.sv
// Shared definitions for the program-counter unit.
//   pc_state_t : BOOT (one cycle after reset), RUN (fetching), HALT (PC held).
//   BR_*       : is_branch encodings from execute. 2'b11 decodes as "no branch".
package pkg_pc;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_t;

  localparam logic [1:0] BR_NONE = 2'b00;
  localparam logic [1:0] BR_COND = 2'b01;
  localparam logic [1:0] BR_JAL  = 2'b10;

endpackage

// File: rtl/module_pc_redirect.sv
// Combinational redirect decode for the PC unit.
//   Inputs : is_jmp, is_branch[1:0], alu_not, alu_out, imm, ex_pc
//   Outputs: taken (a redirect applies), target (next fetch address),
//            misalign (target was misaligned and replaced by TRAP_VECTOR)
// Macro MISALIGN_TRAP_EN enables the misaligned-target trap; when it is not
// defined the computed target is used as-is and misalign is constant 0.
module module_pc_redirect
  import pkg_pc::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] TRAP_VECTOR = 'h4
) (
  input  logic            is_jmp,
  input  logic [1:0]      is_branch,
  input  logic            alu_not,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] ex_pc,
  output logic            taken,
  output logic [XLEN-1:0] target,
  output logic            misalign
);

  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] br_tgt;

  // Branch and JAL share one adder; wraps mod 2^XLEN.
  assign br_tgt = ex_pc + imm;

  // Priority: JALR, then JAL, then a conditional branch whose condition holds.
  always_comb begin
    taken = 1'b0;
    raw   = '0;
    if (is_jmp) begin
      taken = 1'b1;
      raw   = {alu_out[XLEN-1:1], 1'b0};
    end else if (is_branch == BR_JAL) begin
      taken = 1'b1;
      raw   = br_tgt;
    end else if (is_branch == BR_COND && (alu_out[0] ^ alu_not)) begin
      taken = 1'b1;
      raw   = br_tgt;
    end
  end

`ifdef MISALIGN_TRAP_EN
  // JALR bit0 is already cleared in raw, so for jumps only bit1 can trip this.
  assign misalign = taken && (raw[1:0] != 2'b00);
  assign target   = misalign ? TRAP_VECTOR : raw;
`else
  assign misalign = 1'b0;
  assign target   = raw;
`endif

endmodule

// File: rtl/module_pc_unit.sv
// Program-counter unit: generates the fetch address under a valid/ready
// handshake and applies redirects from execute.
//   clock, reset (async active-low)
//   halt                 : level, holds the PC while high
//   is_jmp, is_branch,
//   alu_not, alu_out,
//   imm, ex_pc           : redirect request from execute
//   addr_ready           : fetch accepts addr this cycle
//   addr, addr_valid     : fetch request (addr is purely registered)
//   link                 : ex_pc + STEP, combinational
//   flush                : one-cycle pulse after a redirect was applied
//   misalign             : one-cycle pulse on a trapped misaligned target
// Macro MISALIGN_TRAP_EN enables the misaligned-target trap.
// Reset release is expected to be synchronous to clock.
module module_pc_unit
  import pkg_pc::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            halt,
  input  logic            is_jmp,
  input  logic [1:0]      is_branch,
  input  logic            alu_not,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            addr_ready,
  output logic [XLEN-1:0] addr,
  output logic            addr_valid,
  output logic [XLEN-1:0] link,
  output logic            flush,
  output logic            misalign
);

  pc_state_t       state;
  logic            taken;
  logic            mis_c;
  logic [XLEN-1:0] target;
  logic            redirect;

  module_pc_redirect #(
    .XLEN        (XLEN),
    .TRAP_VECTOR (TRAP_VECTOR)
  ) u_redirect (
    .is_jmp    (is_jmp),
    .is_branch (is_branch),
    .alu_not   (alu_not),
    .alu_out   (alu_out),
    .imm       (imm),
    .ex_pc     (ex_pc),
    .taken     (taken),
    .target    (target),
    .misalign  (mis_c)
  );

  assign link       = ex_pc + XLEN'(STEP);
  assign addr_valid = (state == RUN);
  // BOOT swallows redirects: nothing has been fetched yet.
  assign redirect   = taken && (state != BOOT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= BOOT;
      addr     <= RESET_VECTOR;
      flush    <= 1'b0;
      misalign <= 1'b0;
    end else begin
      flush    <= redirect;
      misalign <= redirect && mis_c;

      // Redirect beats the stall/halt hold; an outstanding unaccepted
      // request is abandoned since fetch discards it on flush.
      if (redirect)
        addr <= target;
      else if (addr_valid && addr_ready && !halt)
        addr <= addr + XLEN'(STEP);

      unique case (state)
        BOOT:    state <= RUN;
        RUN:     state <= halt ? HALT : RUN;
        HALT:    state <= halt ? HALT : RUN;
        default: state <= BOOT;
      endcase
    end
  end

endmodule
